// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: condition codes, instruction modes,
// data-processing opcodes and the ALU command encoding sent to EXE.
package id_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] EXEC_NOP = 4'b0000;
   localparam logic [3:0] EXEC_MOV = 4'b0001;
   localparam logic [3:0] EXEC_MVN = 4'b1001;
   localparam logic [3:0] EXEC_ADD = 4'b0010;
   localparam logic [3:0] EXEC_ADC = 4'b0011;
   localparam logic [3:0] EXEC_SUB = 4'b0100;
   localparam logic [3:0] EXEC_SBC = 4'b0101;
   localparam logic [3:0] EXEC_AND = 4'b0110;
   localparam logic [3:0] EXEC_ORR = 4'b0111;
   localparam logic [3:0] EXEC_EOR = 4'b1000;
   localparam logic [3:0] EXEC_CMP = 4'b0100;
   localparam logic [3:0] EXEC_TST = 4'b0110;

   // nzcv is packed {N,Z,C,V}; code 1111 never passes.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = !z;
         COND_CS: cond_pass = c;
         COND_CC: cond_pass = !c;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = !n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = !v;
         COND_HI: cond_pass = c && !z;
         COND_LS: cond_pass = !c || z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = !z && (n == v);
         COND_LE: cond_pass = z || (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// ID/EX pipeline bundle: the decode stage (master) drives it, EXE (slave) consumes it.
interface id_stage_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              out_valid;
   logic              wb_enable;
   logic              mem_read;
   logic              mem_write;
   logic              b;
   logic              update_status_reg;
   logic              imm;
   logic [3:0]        execute_command;
   logic [31:0]       pc_out;
   logic [DATA_W-1:0] val_rn;
   logic [DATA_W-1:0] val_rm;
   logic [REG_AW-1:0] dest;
   logic [REG_AW-1:0] src1_out;
   logic [REG_AW-1:0] src2_out;
   logic [11:0]       shift_operand;
   logic [23:0]       signed_imm_24;

   modport master (
      output out_valid, wb_enable, mem_read, mem_write, b, update_status_reg, imm,
             execute_command, pc_out, val_rn, val_rm, dest, src1_out, src2_out,
             shift_operand, signed_imm_24
   );

   modport slave (
      input out_valid, wb_enable, mem_read, mem_write, b, update_status_reg, imm,
            execute_command, pc_out, val_rn, val_rm, dest, src1_out, src2_out,
            shift_operand, signed_imm_24
   );
endinterface

// File: rtl/id_stage_pipe_reg_file_bypass.sv
// Register file with two combinational read ports and one write port; a read of
// the register being written this cycle returns the incoming write data.
module reg_file_bypass #(
   parameter  int NUM_REGS = 16,
   parameter  int DATA_W   = 32,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [AW-1:0]     raddr2,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
      rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with built-in ID/EX register: field/control decode, condition check,
// register read with write-first bypass, RAW hazard detection, stall/freeze/flush.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 16,
   parameter  int FWD_EN   = 0,
   localparam int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [31:0]       instruction,
   input  logic [31:0]       pc_in,
   input  logic [3:0]        str_out,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic              exe_wb_en,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              exe_mem_read,
   input  logic              freeze,
   input  logic              flush,
   output logic              hazard,
   id_stage_pipe_if.master   ex
);

   logic [3:0] cond, opcode;
   logic [1:0] mode;
   logic       i_bit, s_bit;
   logic [REG_AW-1:0] rn, rd, rm, src1, src2;

   assign cond   = instruction[31:28];
   assign mode   = instruction[27:26];
   assign i_bit  = instruction[25];
   assign opcode = instruction[24:21];
   assign s_bit  = instruction[20];
   assign rn     = REG_AW'(instruction[19:16]);
   assign rd     = REG_AW'(instruction[15:12]);
   assign rm     = REG_AW'(instruction[3:0]);

   logic       dp_valid, is_mem, is_str;
   logic       c_wb, c_mem_read, c_mem_write, c_b, c_upd, c_imm;
   logic [3:0] c_cmd;

   // Unsupported data-processing opcodes and mode 11 decode to all-zero controls.
   always_comb begin
      dp_valid    = 1'b0;
      is_mem      = 1'b0;
      is_str      = 1'b0;
      c_wb        = 1'b0;
      c_mem_read  = 1'b0;
      c_mem_write = 1'b0;
      c_b         = 1'b0;
      c_upd       = 1'b0;
      c_imm       = 1'b0;
      c_cmd       = EXEC_NOP;
      case (mode)
         MODE_DP: begin
            dp_valid = 1'b1;
            case (opcode)
               OP_MOV:  c_cmd = EXEC_MOV;
               OP_MVN:  c_cmd = EXEC_MVN;
               OP_ADD:  c_cmd = EXEC_ADD;
               OP_ADC:  c_cmd = EXEC_ADC;
               OP_SUB:  c_cmd = EXEC_SUB;
               OP_SBC:  c_cmd = EXEC_SBC;
               OP_AND:  c_cmd = EXEC_AND;
               OP_ORR:  c_cmd = EXEC_ORR;
               OP_EOR:  c_cmd = EXEC_EOR;
               OP_CMP:  c_cmd = EXEC_CMP;
               OP_TST:  c_cmd = EXEC_TST;
               default: dp_valid = 1'b0;
            endcase
            if (dp_valid) begin
               c_wb  = !(opcode == OP_CMP || opcode == OP_TST);
               c_upd = s_bit;
               c_imm = i_bit;
            end
         end
         MODE_MEM: begin
            is_mem = 1'b1;
            c_cmd  = EXEC_ADD;
            c_imm  = i_bit;
            if (s_bit) begin
               c_wb       = 1'b1;
               c_mem_read = 1'b1;
            end else begin
               c_mem_write = 1'b1;
               is_str      = 1'b1;
            end
         end
         MODE_BR: begin
            c_b   = 1'b1;
            c_imm = i_bit;
         end
         default: ;
      endcase
   end

   logic uses_src1, uses_src2;
   assign src1      = rn;
   assign src2      = is_str ? rd : rm;
   assign uses_src1 = (dp_valid && opcode != OP_MOV && opcode != OP_MVN) || is_mem;
   assign uses_src2 = (dp_valid && !i_bit) || is_str;

   logic raw_hit;
   generate
      if (FWD_EN != 0) begin : g_fwd
         // Forwarding covers everything except a load still in EXE.
         assign raw_hit = exe_mem_read && exe_wb_en &&
                          ((uses_src1 && exe_dest == src1) || (uses_src2 && exe_dest == src2));
      end else begin : g_nofwd
         assign raw_hit =
            (uses_src1 && ((exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1))) ||
            (uses_src2 && ((exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2)));
      end
   endgenerate

   assign hazard = in_valid && !flush && raw_hit;

   logic [DATA_W-1:0] rd_val1, rd_val2;

   reg_file_bypass #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_en),
      .waddr  (wb_dest),
      .wdata  (wb_value),
      .raddr1 (src1),
      .rdata1 (rd_val1),
      .raddr2 (src2),
      .rdata2 (rd_val2)
   );

   logic issue;
   assign issue = in_valid && !flush && !hazard && cond_pass(cond, str_out);

   always_ff @(posedge clk) begin
      if (!rst || (!freeze && !issue)) begin
         ex.out_valid         <= 1'b0;
         ex.wb_enable         <= 1'b0;
         ex.mem_read          <= 1'b0;
         ex.mem_write         <= 1'b0;
         ex.b                 <= 1'b0;
         ex.update_status_reg <= 1'b0;
         ex.imm               <= 1'b0;
         ex.execute_command   <= '0;
         ex.pc_out            <= '0;
         ex.val_rn            <= '0;
         ex.val_rm            <= '0;
         ex.dest              <= '0;
         ex.src1_out          <= '0;
         ex.src2_out          <= '0;
         ex.shift_operand     <= '0;
         ex.signed_imm_24     <= '0;
      end else if (!freeze) begin
         ex.out_valid         <= 1'b1;
         ex.wb_enable         <= c_wb;
         ex.mem_read          <= c_mem_read;
         ex.mem_write         <= c_mem_write;
         ex.b                 <= c_b;
         ex.update_status_reg <= c_upd;
         ex.imm               <= c_imm;
         ex.execute_command   <= c_cmd;
         ex.pc_out            <= pc_in;
         ex.val_rn            <= rd_val1;
         ex.val_rm            <= rd_val2;
         ex.dest              <= rd;
         ex.src1_out          <= src1;
         ex.src2_out          <= src2;
         ex.shift_operand     <= instruction[11:0];
         ex.signed_imm_24     <= instruction[23:0];
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one no-forwarding and one forwarding instance
// share the same stimulus; each scenario task checks its own hand-computed values.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] pc_in = '0;
   logic [3:0]  str_out = '0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_dest = '0;
   logic [31:0] wb_value = '0;
   logic        exe_wb_en = 1'b0, mem_wb_en = 1'b0;
   logic [3:0]  exe_dest = '0, mem_dest = '0;
   logic        exe_mem_read = 1'b0;
   logic        freeze = 1'b0, flush = 1'b0;
   logic        hazard0, hazard1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_stage_pipe_if #(.DATA_W(32), .REG_AW(4)) ex0 ();
   id_stage_pipe_if #(.DATA_W(32), .REG_AW(4)) ex1 ();

   id_stage_pipe #(.DATA_W(32), .NUM_REGS(16), .FWD_EN(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
      .str_out(str_out), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
      .exe_mem_read(exe_mem_read), .freeze(freeze), .flush(flush), .hazard(hazard0), .ex(ex0)
   );

   id_stage_pipe #(.DATA_W(32), .NUM_REGS(16), .FWD_EN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
      .str_out(str_out), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
      .exe_mem_read(exe_mem_read), .freeze(freeze), .flush(flush), .hazard(hazard1), .ex(ex1)
   );

   localparam logic [3:0] AL = 4'b1110;

   function automatic logic [31:0] dp_instr(input logic [3:0] c, input logic i, input logic [3:0] op,
                                            input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                            input logic [11:0] op2);
      return {c, 2'b00, i, op, s, rn, rd, op2};
   endfunction

   function automatic logic [31:0] mem_instr(input logic l, input logic [3:0] rn, input logic [3:0] rd);
      return {AL, 2'b01, 1'b0, 4'b1100, l, rn, rd, 12'h000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      n_vec++; if (ex0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h exp 0", ex0.out_valid); end
      n_vec++; if (ex0.execute_command !== 4'h0) begin n_err++; $display("FAIL rst_cmd: got %0h exp 0", ex0.execute_command); end
      n_vec++; if (ex0.val_rn !== 32'h0) begin n_err++; $display("FAIL rst_val_rn: got %0h exp 0", ex0.val_rn); end
      n_vec++; if (ex0.pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %0h exp 0", ex0.pc_out); end
      n_vec++; if (ex0.signed_imm_24 !== 24'h0) begin n_err++; $display("FAIL rst_imm24: got %0h exp 0", ex0.signed_imm_24); end
      n_vec++; if (hazard0 !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %0h exp 0", hazard0); end
      rst = 1'b1;
   endtask

   task automatic test_wb_bypass();
      in_valid    = 1'b1;
      instruction = dp_instr(AL, 1'b0, 4'b0100, 1'b0, 4'd3, 4'd1, 12'h002);  // ADD R1,R3,R2
      pc_in       = 32'h100;
      wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h55;
      step();
      wb_en = 1'b0;
      n_vec++; if (ex0.val_rn !== 32'h55) begin n_err++; $display("FAIL bypass_val_rn: got %0h exp 55", ex0.val_rn); end
      n_vec++; if (ex0.val_rm !== 32'h0) begin n_err++; $display("FAIL bypass_val_rm: got %0h exp 0", ex0.val_rm); end
      n_vec++; if (ex0.execute_command !== 4'b0010) begin n_err++; $display("FAIL bypass_cmd: got %0h exp 2", ex0.execute_command); end
      n_vec++; if (ex0.out_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid: got %0h exp 1", ex0.out_valid); end
      n_vec++; if (ex0.pc_out !== 32'h100) begin n_err++; $display("FAIL bypass_pc: got %0h exp 100", ex0.pc_out); end
      n_vec++; if (ex0.dest !== 4'd1) begin n_err++; $display("FAIL bypass_dest: got %0h exp 1", ex0.dest); end
      n_vec++; if (ex0.wb_enable !== 1'b1) begin n_err++; $display("FAIL bypass_wb: got %0h exp 1", ex0.wb_enable); end
   endtask

   task automatic test_hazard();
      instruction = dp_instr(AL, 1'b0, 4'b0010, 1'b0, 4'd3, 4'd1, 12'h002);  // SUB R1,R3,R2
      pc_in = 32'h104;
      exe_wb_en = 1'b1; exe_dest = 4'd3; exe_mem_read = 1'b0;
      #1;
      n_vec++; if (hazard0 !== 1'b1) begin n_err++; $display("FAIL hz_nofwd: got %0h exp 1", hazard0); end
      n_vec++; if (hazard1 !== 1'b0) begin n_err++; $display("FAIL hz_fwd_alu: got %0h exp 0", hazard1); end
      step();
      n_vec++; if (ex0.out_valid !== 1'b0) begin n_err++; $display("FAIL hz_bubble_valid: got %0h exp 0", ex0.out_valid); end
      n_vec++; if (ex0.wb_enable !== 1'b0) begin n_err++; $display("FAIL hz_bubble_wb: got %0h exp 0", ex0.wb_enable); end
      n_vec++; if (ex1.out_valid !== 1'b1) begin n_err++; $display("FAIL hz_fwd_issue: got %0h exp 1", ex1.out_valid); end
      n_vec++; if (ex1.execute_command !== 4'b0100) begin n_err++; $display("FAIL hz_fwd_cmd: got %0h exp 4", ex1.execute_command); end
      exe_mem_read = 1'b1;
      #1;
      n_vec++; if (hazard1 !== 1'b1) begin n_err++; $display("FAIL hz_fwd_load_rn: got %0h exp 1", hazard1); end
      exe_dest = 4'd2;
      #1;
      n_vec++; if (hazard1 !== 1'b1) begin n_err++; $display("FAIL hz_fwd_load_rm: got %0h exp 1", hazard1); end
      flush = 1'b1;
      #1;
      n_vec++; if (hazard1 !== 1'b0) begin n_err++; $display("FAIL hz_flush_fwd: got %0h exp 0", hazard1); end
      n_vec++; if (hazard0 !== 1'b0) begin n_err++; $display("FAIL hz_flush_nofwd: got %0h exp 0", hazard0); end
      flush = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      mem_wb_en = 1'b1; mem_dest = 4'd2;
      #1;
      n_vec++; if (hazard0 !== 1'b1) begin n_err++; $display("FAIL hz_mem_nofwd: got %0h exp 1", hazard0); end
      n_vec++; if (hazard1 !== 1'b0) begin n_err++; $display("FAIL hz_mem_fwd: got %0h exp 0", hazard1); end
      instruction = dp_instr(AL, 1'b1, 4'b1101, 1'b0, 4'd2, 4'd1, 12'h002);  // MOV R1,#2 reads nothing
      #1;
      n_vec++; if (hazard0 !== 1'b0) begin n_err++; $display("FAIL hz_mov_imm: got %0h exp 0", hazard0); end
      mem_wb_en = 1'b0;
      instruction = dp_instr(AL, 1'b0, 4'b0010, 1'b0, 4'd3, 4'd1, 12'h002);
      step();
      n_vec++; if (ex0.out_valid !== 1'b1) begin n_err++; $display("FAIL hz_release_valid: got %0h exp 1", ex0.out_valid); end
      n_vec++; if (ex0.execute_command !== 4'b0100) begin n_err++; $display("FAIL hz_release_cmd: got %0h exp 4", ex0.execute_command); end
      n_vec++; if (ex0.val_rn !== 32'h55) begin n_err++; $display("FAIL hz_release_rn: got %0h exp 55", ex0.val_rn); end
   endtask

   task automatic test_cond();
      logic [3:0] conds [8] = '{4'b0000, 4'b0000, 4'b1100, 4'b1010, 4'b1000, 4'b1001, 4'b1111, 4'b1110};
      logic [3:0] flags [8] = '{4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b0010, 4'b0010, 4'b1111, 4'b0000};
      logic       pass  [8] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
      for (int k = 0; k < 8; k++) begin
         instruction = dp_instr(conds[k], 1'b0, 4'b0100, 1'b0, 4'd3, 4'd1, 12'h002);
         str_out = flags[k];
         step();
         n_vec++; if (ex0.out_valid !== pass[k]) begin n_err++; $display("FAIL cond_%0d_valid: got %0h exp %0h", k, ex0.out_valid, pass[k]); end
         n_vec++; if (ex0.wb_enable !== pass[k]) begin n_err++; $display("FAIL cond_%0d_wb: got %0h exp %0h", k, ex0.wb_enable, pass[k]); end
      end
      str_out = 4'b0000;
   endtask

   task automatic test_decode();
      instruction = mem_instr(1'b0, 4'd2, 4'd5);  // STR R5,[R2]
      step();
      n_vec++; if (ex0.src2_out !== 4'd5) begin n_err++; $display("FAIL str_src2: got %0h exp 5", ex0.src2_out); end
      n_vec++; if (ex0.src1_out !== 4'd2) begin n_err++; $display("FAIL str_src1: got %0h exp 2", ex0.src1_out); end
      n_vec++; if (ex0.mem_write !== 1'b1) begin n_err++; $display("FAIL str_mem_write: got %0h exp 1", ex0.mem_write); end
      n_vec++; if (ex0.wb_enable !== 1'b0) begin n_err++; $display("FAIL str_wb: got %0h exp 0", ex0.wb_enable); end
      n_vec++; if (ex0.execute_command !== 4'b0010) begin n_err++; $display("FAIL str_cmd: got %0h exp 2", ex0.execute_command); end
      instruction = mem_instr(1'b1, 4'd3, 4'd4);  // LDR R4,[R3]
      step();
      n_vec++; if ({ex0.mem_read, ex0.wb_enable, ex0.mem_write} !== 3'b110) begin n_err++; $display("FAIL ldr_ctl: got %0b exp 110", {ex0.mem_read, ex0.wb_enable, ex0.mem_write}); end
      n_vec++; if (ex0.val_rn !== 32'h55) begin n_err++; $display("FAIL ldr_rn: got %0h exp 55", ex0.val_rn); end
      instruction = dp_instr(AL, 1'b0, 4'b1010, 1'b1, 4'd3, 4'd0, 12'h006);  // CMP R3,R6
      step();
      n_vec++; if (ex0.update_status_reg !== 1'b1) begin n_err++; $display("FAIL cmp_upd: got %0h exp 1", ex0.update_status_reg); end
      n_vec++; if (ex0.wb_enable !== 1'b0) begin n_err++; $display("FAIL cmp_wb: got %0h exp 0", ex0.wb_enable); end
      n_vec++; if (ex0.execute_command !== 4'b0100) begin n_err++; $display("FAIL cmp_cmd: got %0h exp 4", ex0.execute_command); end
      instruction = {AL, 2'b10, 2'b10, 24'hABCDEF};  // B
      step();
      n_vec++; if (ex0.b !== 1'b1) begin n_err++; $display("FAIL br_b: got %0h exp 1", ex0.b); end
      n_vec++; if (ex0.signed_imm_24 !== 24'hABCDEF) begin n_err++; $display("FAIL br_imm24: got %0h exp abcdef", ex0.signed_imm_24); end
      n_vec++; if (ex0.execute_command !== 4'b0000) begin n_err++; $display("FAIL br_cmd: got %0h exp 0", ex0.execute_command); end
      instruction = {AL, 2'b11, 26'h3FFFFFF};  // mode 11
      step();
      n_vec++; if ({ex0.wb_enable, ex0.mem_read, ex0.mem_write, ex0.b, ex0.update_status_reg, ex0.imm, ex0.execute_command} !== 10'h0) begin
         n_err++; $display("FAIL mode3_ctl: got %0h exp 0", {ex0.wb_enable, ex0.mem_read, ex0.mem_write, ex0.b, ex0.update_status_reg, ex0.imm, ex0.execute_command});
      end
   endtask

   task automatic test_freeze_flush();
      instruction = dp_instr(AL, 1'b1, 4'b1101, 1'b0, 4'd0, 4'd7, 12'h0AB);  // MOV R7,#0xAB
      pc_in = 32'h200;
      step();
      n_vec++; if (ex0.execute_command !== 4'b0001) begin n_err++; $display("FAIL mov_cmd: got %0h exp 1", ex0.execute_command); end
      n_vec++; if (ex0.imm !== 1'b1) begin n_err++; $display("FAIL mov_imm: got %0h exp 1", ex0.imm); end
      freeze = 1'b1;
      wb_en = 1'b1; wb_dest = 4'd6; wb_value = 32'h66;
      for (int k = 0; k < 3; k++) begin
         instruction = dp_instr(AL, 1'b0, 4'b0100, 1'b0, 4'd3, 4'd1, 12'h002);
         pc_in = 32'h204 + 32'(4 * k);
         step();
         wb_en = 1'b0;
         n_vec++; if (ex0.dest !== 4'd7) begin n_err++; $display("FAIL frz_%0d_dest: got %0h exp 7", k, ex0.dest); end
         n_vec++; if (ex0.shift_operand !== 12'h0AB) begin n_err++; $display("FAIL frz_%0d_shift: got %0h exp ab", k, ex0.shift_operand); end
         n_vec++; if (ex0.pc_out !== 32'h200) begin n_err++; $display("FAIL frz_%0d_pc: got %0h exp 200", k, ex0.pc_out); end
      end
      flush = 1'b1;
      step();
      n_vec++; if (ex0.out_valid !== 1'b1 || ex0.dest !== 4'd7) begin n_err++; $display("FAIL frz_flush_hold: got %0h/%0h exp 1/7", ex0.out_valid, ex0.dest); end
      freeze = 1'b0;
      step();
      n_vec++; if (ex0.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0h exp 0", ex0.out_valid); end
      n_vec++; if (ex0.dest !== 4'd0) begin n_err++; $display("FAIL flush_dest: got %0h exp 0", ex0.dest); end
      flush = 1'b0;
      instruction = dp_instr(AL, 1'b0, 4'b0100, 1'b0, 4'd6, 4'd1, 12'h002);  // ADD R1,R6,R2
      step();
      n_vec++; if (ex0.val_rn !== 32'h66) begin n_err++; $display("FAIL frz_rf_write: got %0h exp 66", ex0.val_rn); end
      freeze = 1'b1;
      rst = 1'b0;
      step();
      n_vec++; if (ex0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_frz_valid: got %0h exp 0", ex0.out_valid); end
      n_vec++; if (ex0.val_rn !== 32'h0) begin n_err++; $display("FAIL rst_frz_rn: got %0h exp 0", ex0.val_rn); end
      n_vec++; if (ex0.execute_command !== 4'h0) begin n_err++; $display("FAIL rst_frz_cmd: got %0h exp 0", ex0.execute_command); end
      rst = 1'b1;
      freeze = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wb_bypass();
      test_hazard();
      test_cond();
      test_decode();
      test_freeze_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage with the ID/EX pipeline register built in.
- Decodes the ARM-subset instruction and checks its condition against NZCV.
- Reads a write-first register file, detects RAW hazards against EXE/MEM destinations, and drives registered controls/operands to EXE.
- Sits between the IF/ID register and the EXE stage. Supports stall, freeze and flush with a valid bit.

Parameters:
- DATA_W, 32, register and operand width.
- NUM_REGS, 16, register file depth; REG_AW = $clog2(NUM_REGS), must be ≥4.
- FWD_EN, 0: 0 means any pending EXE/MEM write to a used source is a hazard; 1 means only an EXE-stage load is a hazard (forwarding unit exists).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets.
- in_valid  in  1  IF/ID slot holds a real instruction.
- instruction  in  32  instruction word.
- pc_in  in  32  PC of the instruction.
- str_out  in  4  status {N,Z,C,V}.
- wb_en  in  1  writeback enable.
- wb_dest  in  REG_AW  writeback register.
- wb_value  in  DATA_W  writeback data.
- exe_wb_en, mem_wb_en  in  1  EXE/MEM instruction will write a register.
- exe_dest, mem_dest  in  REG_AW  their destinations.
- exe_mem_read  in  1  EXE instruction is a load.
- freeze  in  1  hold ID/EX contents (memory stall).
- flush  in  1  branch taken; squash the current decode.
- hazard  out  1  combinational; IF and IF/ID must stall.
- out_valid, wb_enable, mem_read, mem_write, b, update_status_reg, imm  out  1  registered controls.
- execute_command  out  4  registered ALU command.
- pc_out  out  32  registered PC.
- val_rn, val_rm  out  DATA_W  registered operands.
- dest, src1_out, src2_out  out  REG_AW  registered; sources go to the forwarding unit.
- shift_operand  out  12  registered.
- signed_imm_24  out  24  registered.

Behaviour:
- Field decode:
  - cond = [31:28], I = [25], mode = [27:26], opcode = [24:21], S = [20].
  - Rn = [19:16], Rd = [15:12], Rm = [3:0].
  - The low REG_AW bits of each register field are used.
- Control decode:
  - mode 00 is data processing, with the shared execute_command table.
  - mode 01 is memory: S=1 is LDR (wb, mem_read, cmd 0010); S=0 is STR (mem_write, cmd 0010).
  - mode 10 is B (b=1, cmd 0000).
  - mode 11 is invalid and decodes all controls to 0.
  - update_status_reg = S in mode 00 only.
  - CMP and TST force wb_enable = 0.
- Condition: the full 15-code ARM table over str_out; AL=1110 passes; 1111 fails.
- Sources:
  - src1 = Rn.
  - src2 = Rd for STR, otherwise Rm.
  - uses_src1 = valid data-processing op other than MOV/MVN, or a memory op.
  - uses_src2 = (data-processing op with I=0) or STR.
- hazard:
  - FWD_EN=0: in_valid & ((uses_src1 & ((exe_wb_en & exe_dest==src1) | (mem_wb_en & mem_dest==src1))) | the same for src2).
  - FWD_EN=1: in_valid & exe_mem_read & exe_wb_en & ((uses_src1 & exe_dest==src1) | (uses_src2 & exe_dest==src2)).
  - flush forces hazard to 0.
- Register file:
  - NUM_REGS × DATA_W; written on the rising edge when wb_en=1.
  - Combinational reads with write-first bypass: when wb_en & wb_dest==src, the operand is wb_value.
  - Reset clears all registers to 0.
- ID/EX update at each rising edge, in priority order:
  1. rst==0: every output register is 0, including out_valid. Takes effect the same edge even mid-stall.
  2. freeze: all ID/EX outputs hold; the register file still writes.
  3. flush: bubble.
  4. hazard: bubble.
  5. in_valid==0 or condition fails: bubble.
  6. Otherwise load the decoded fields; out_valid=1.
- A bubble sets out_valid and all control outputs to 0. Data fields are don't-care and are driven 0.
- Latency is one cycle from instruction to registered outputs.
- freeze and flush together: the freeze holds, and the flush must be reasserted by its source.
- Reset output values: every output 0 except hazard, which is combinational.

Decomposition:
- Package id_pkg holds:
  - cond codes;
  - mode codes MODE_DP/MODE_MEM/MODE_BR;
  - opcode constants;
  - EXEC_* commands (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 0100, TST 0110).
- One sub-module, reg_file_bypass (NUM_REGS, DATA_W), with two read ports and one write port, write-first.

Test Plan:
- Write R3=0x55 with wb_en while decoding ADD R1,R3,R2 in the same cycle. Next cycle val_rn=0x55, execute_command=0010, out_valid=1.
- FWD_EN=0, exe_wb_en=1, exe_dest=3, decode SUB R1,R3,R2 → hazard=1 and a bubble next cycle. Deassert exe_wb_en → instruction issues with cmd 0100.
- FWD_EN=1, same case with exe_mem_read=0 → hazard=0. With exe_mem_read=1 → hazard=1.
- str_out Z=0 and ADDEQ → out_valid=0 and all controls 0. Z=1 → issues.
- freeze=1 for 3 cycles while new instructions arrive → outputs hold the prior values. flush=1 → bubble. rst=0 mid-freeze → all outputs 0 next edge.
- STR R5,[R2] → src2_out=5, mem_write=1, wb_enable=0. CMP with S=1 → update_status_reg=1, wb_enable=0.
